// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and duty (percent) of an asynchronous PWM input.
// A two-flop synchroniser feeds an edge-driven measurement FSM and a serial restoring divider.
module pwm_capture #(
    parameter int CW      = 24,
    parameter int TIMEOUT = 5_000_000
) (
    input  logic          CLK,
    input  logic          Rstn,
    input  logic          PWM_In,
    output logic [CW-1:0] Count_P,
    output logic [CW-1:0] Count_D,
    output logic [7:0]    Duty,
    output logic          Valid,
    output logic          Timeout,
    output logic          Overrun
);
    localparam int NW = CW + 7;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic {S_WAIT, S_MEAS} state_t;
    typedef enum logic {D_IDLE, D_RUN} dstate_t;

    logic          s1_q, s2_q, s3_q;
    state_t        st_q;
    logic [CW-1:0] cnt_p_q, cnt_h_q;
    dstate_t       ds_q;
    logic [NW-1:0] rem_q, dsr_q;
    logic [7:0]    quo_q;
    logic [2:0]    it_q;
    logic [CW-1:0] op_p_q, op_h_q, fin_p_q, fin_h_q;
    logic [7:0]    fin_d_q;
    logic          done_q;
    logic [CW-1:0] cp_q, cd_q;
    logic [7:0]    duty_q;
    logic          valid_q, tmo_q, ovr_q;
    logic          rise, snap, tmo, last, ge, load;

    assign rise = s2_q & ~s3_q;
    assign snap = (st_q == S_MEAS) && rise;
    assign tmo  = (st_q == S_MEAS) && !rise && (cnt_p_q == TMO);
    assign last = (ds_q == D_RUN) && (it_q == 3'd7);
    assign ge   = rem_q >= dsr_q;
    // The divider accepts a new snapshot in its final iteration cycle, since the result is parked in fin_*.
    assign load = snap && (ds_q == D_IDLE || last);

    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            st_q    <= S_WAIT;
            cnt_p_q <= '0;
            cnt_h_q <= '0;
        end else begin
            s1_q <= PWM_In;
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (rise) begin
                st_q    <= S_MEAS;
                cnt_p_q <= CW'(1);
                cnt_h_q <= CW'(1);
            end else if (st_q == S_WAIT || tmo) begin
                st_q    <= S_WAIT;
                cnt_p_q <= '0;
                cnt_h_q <= '0;
            end else begin
                cnt_p_q <= cnt_p_q + CW'(1);
                cnt_h_q <= cnt_h_q + CW'(s2_q);
            end
        end
    end

    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            ds_q    <= D_IDLE;
            rem_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            it_q    <= '0;
            op_p_q  <= '0;
            op_h_q  <= '0;
            fin_p_q <= '0;
            fin_h_q <= '0;
            fin_d_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (last) begin
                fin_p_q <= op_p_q;
                fin_h_q <= op_h_q;
                fin_d_q <= {quo_q[6:0], ge};
            end
            if (load) begin
                ds_q   <= D_RUN;
                it_q   <= '0;
                rem_q  <= NW'(cnt_h_q) * NW'(100);
                dsr_q  <= {cnt_p_q, 7'd0};
                quo_q  <= '0;
                op_p_q <= cnt_p_q;
                op_h_q <= cnt_h_q;
            end else if (ds_q == D_RUN) begin
                rem_q <= ge ? rem_q - dsr_q : rem_q;
                dsr_q <= dsr_q >> 1;
                quo_q <= {quo_q[6:0], ge};
                it_q  <= it_q + 3'd1;
                if (last)
                    ds_q <= D_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            cp_q    <= '0;
            cd_q    <= '0;
            duty_q  <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= tmo | done_q;
            ovr_q   <= snap & ~load;
            if (tmo) begin
                cp_q   <= '0;
                cd_q   <= '0;
                duty_q <= s2_q ? 8'd100 : 8'd0;
            end else if (done_q) begin
                cp_q   <= fin_p_q;
                cd_q   <= fin_h_q;
                duty_q <= fin_d_q;
            end
            if (rise)
                tmo_q <= 1'b0;
            else if (tmo)
                tmo_q <= 1'b1;
        end
    end

    assign Count_P = cp_q;
    assign Count_D = cd_q;
    assign Duty    = duty_q;
    assign Valid   = valid_q;
    assign Timeout = tmo_q;
    assign Overrun = ovr_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM waveforms with hand-computed period, high time and duty.
module tb_pwm_capture;
    localparam int CW  = 24;
    localparam int TMO = 2000;

    logic          CLK = 1'b0;
    logic          Rstn = 1'b0;
    logic          PWM_In = 1'b0;
    logic [CW-1:0] Count_P, Count_D;
    logic [7:0]    Duty;
    logic          Valid, Timeout, Overrun;

    int total = 0, bad = 0;
    int cyc = 0, rcyc = 0, vcyc = 0, vcnt = 0, ocnt = 0;
    int v0, o0;
    logic pwm_prev = 1'b0;

    pwm_capture #(.CW(CW), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .Rstn(Rstn), .PWM_In(PWM_In),
        .Count_P(Count_P), .Count_D(Count_D), .Duty(Duty),
        .Valid(Valid), .Timeout(Timeout), .Overrun(Overrun)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        cyc++;
        if (PWM_In && !pwm_prev)
            rcyc = cyc;
        pwm_prev = PWM_In;
        if (Valid) begin
            vcnt++;
            vcyc = cyc;
        end
        if (Overrun)
            ocnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        @(posedge CLK);
        #2 PWM_In = v;
        repeat (n - 1) @(posedge CLK);
    endtask

    task automatic pwm(input int per, input int hi, input int n);
        repeat (n) begin
            hold(1'b1, hi);
            hold(1'b0, per - hi);
        end
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic check_out(input string tag, input int p, input int d, input int du);
        check({tag, "_p"}, int'(Count_P), p);
        check({tag, "_d"}, int'(Count_D), d);
        check({tag, "_duty"}, int'(Duty), du);
    endtask

    initial begin
        hold(1'b0, 5);
        Rstn = 1'b1;
        pwm(100, 50, 3);
        settle();
        check_out("pre", 100, 50, 50);
        hold(1'b1, 10);
        Rstn = 1'b0;
        settle();
        check_out("rst", 0, 0, 0);
        check("rst_valid", int'(Valid), 0);
        check("rst_tmo", int'(Timeout), 0);
        check("rst_ovr", int'(Overrun), 0);
        hold(1'b0, 10);
        Rstn = 1'b1;
        hold(1'b0, 10);
        settle();
        check_out("rel", 0, 0, 0);
        v0 = vcnt;
        pwm(1000, 250, 1);
        settle();
        check("first_rise_novalid", vcnt - v0, 0);
        hold(1'b1, 250);
        hold(1'b0, 750);
        settle();
        check("second_rise_valid", vcnt - v0, 1);
        check("latency", vcyc - rcyc, 12);
        check_out("d25", 1000, 250, 25);

        pwm(1000, 333, 2);
        settle();
        check_out("d33", 1000, 333, 33);
        pwm(1000, 999, 2);
        settle();
        check_out("d99", 1000, 999, 99);

        hold(1'b1, 20);
        settle();
        v0 = vcnt;
        hold(1'b1, TMO);
        settle();
        check("tmo_hi", int'(Timeout), 1);
        check("tmo_hi_valid", vcnt - v0, 1);
        check_out("tmo_hi", 0, 0, 100);
        hold(1'b0, 10);
        hold(1'b1, 10);
        settle();
        check("tmo_clr1", int'(Timeout), 0);
        v0 = vcnt;
        hold(1'b0, TMO + 10);
        settle();
        check("tmo_lo", int'(Timeout), 1);
        check("tmo_lo_valid", vcnt - v0, 1);
        check_out("tmo_lo", 0, 0, 0);
        v0 = vcnt;
        hold(1'b1, 50);
        settle();
        check("tmo_clr2", int'(Timeout), 0);
        check("resume_novalid", vcnt - v0, 0);
        hold(1'b0, 50);
        hold(1'b1, 30);
        settle();
        check("resume_valid", vcnt - v0, 1);
        check_out("resume", 100, 50, 50);

        hold(1'b0, 20);
        v0 = vcnt;
        o0 = ocnt;
        pwm(4, 2, 20);
        hold(1'b0, 20);
        settle();
        check("ovr_count", ocnt - o0, 10);
        check("ovr_valid", vcnt - v0, 10);
        check_out("ovr", 4, 2, 50);

        pwm(100, 50, 3);
        hold(1'b1, 150);
        settle();
        check_out("p100", 100, 50, 50);
        hold(1'b0, 150);
        v0 = vcnt;
        hold(1'b1, 20);
        settle();
        check("p300_valid", vcnt - v0, 1);
        check_out("p300", 300, 150, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
